// File: rtl/time_pkg.sv
// Shared definitions for the time counter stages: widths, set-handshake FSM
// encoding and the binary-to-BCD digit split.
package time_pkg;

  localparam int HOURS_MAX = 23;
  localparam int HOURS_W   = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } set_state_e;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Covers 0-59 so minutes/seconds stages can share it.
  function automatic bcd_t bcd_split(input logic [6:0] v);
    bcd_t r;
    r.tens  = 3'(v / 7'd10);
    r.units = 4'(v % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle rising-edge pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  // [SYNC_STAGES-1] is the synchronised level, [SYNC_STAGES] its delayed copy.
  logic [SYNC_STAGES:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe  <= '0;
      rise_pulse <= 1'b0;
    end else begin
      sync_pipe  <= {sync_pipe[SYNC_STAGES-1:0], async_in};
      rise_pulse <= sync_pipe[SYNC_STAGES-1] & ~sync_pipe[SYNC_STAGES];
    end
  end

endmodule

// File: rtl/hours_counter.sv
// Hours stage: counts synchronised hour ticks 0-23, drives binary/BCD/pm
// display values and a midnight day_tick, and accepts a four-phase time set.
module hours_counter
  import time_pkg::*;
#(
  parameter bit MODE_24H    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hours_clk,
  input  logic               hold,
  input  logic               set_valid,
  input  logic [HOURS_W-1:0] set_value,
  output logic               set_ack,
  output logic               set_err,
  output logic [HOURS_W-1:0] hours_bin,
  output logic [1:0]         hours_tens,
  output logic [3:0]         hours_units,
  output logic               pm,
  output logic               day_tick
);

  localparam logic [HOURS_W-1:0] MAX_H = HOURS_W'(HOURS_MAX);
  localparam logic [HOURS_W-1:0] NOON  = HOURS_W'(12);

  logic               tick;
  set_state_e         state, state_nxt;
  logic               err_q;
  logic [HOURS_W-1:0] hours_nxt;
  logic [HOURS_W-1:0] disp;
  logic               wrap;
  bcd_t               bcd;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (hours_clk),
    .rise_pulse (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (set_valid) state_nxt = LOAD;
      LOAD:    state_nxt = ACK;
      ACK:     state_nxt = WAIT;
      WAIT:    if (!set_valid) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    set_ack = (state == ACK);
    set_err = (state == ACK) && err_q;
  end

  // A tick in the cycle that leaves RUN for LOAD is dropped: the set wins.
  always_comb begin
    hours_nxt = hours_bin;
    wrap      = 1'b0;
    if (state == RUN && !set_valid && tick && !hold) begin
      if (hours_bin == MAX_H) begin
        hours_nxt = '0;
        wrap      = 1'b1;
      end else begin
        hours_nxt = hours_bin + 5'd1;
      end
    end else if (state == LOAD && set_value <= MAX_H) begin
      hours_nxt = set_value;
    end
  end

  // Display digits derive from the next value so all outputs move together.
  always_comb begin
    disp = hours_nxt;
    if (!MODE_24H) begin
      if (hours_nxt >= NOON) disp = hours_nxt - NOON;
      if (disp == '0)        disp = NOON;
    end
    bcd = bcd_split({2'b00, disp});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hours_bin   <= '0;
      hours_tens  <= MODE_24H ? 2'd0 : 2'd1;
      hours_units <= MODE_24H ? 4'd0 : 4'd2;
      pm          <= 1'b0;
      day_tick    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hours_bin   <= hours_nxt;
      hours_tens  <= 2'(bcd.tens);
      hours_units <= bcd.units;
      pm          <= !MODE_24H && (hours_nxt >= NOON);
      day_tick    <= wrap;
      if (state == LOAD) err_q <= (set_value > MAX_H);
    end
  end

endmodule
